// File: rtl/ras_if.sv
// Return address stack bus: push/pop requests, checkpoint outputs and restore inputs.
interface ras_if #(
    parameter int unsigned RAS_DEPTH        = 8,
    parameter int unsigned LOG_RAS_DEPTH    = $clog2(RAS_DEPTH),
    parameter int unsigned RAS_TARGET_WIDTH = 8
);
    logic                        link_valid;
    logic [RAS_TARGET_WIDTH-1:0] link_target;
    logic                        ret_valid;
    logic [RAS_TARGET_WIDTH-1:0] ret_target;
    logic                        ret_empty;
    logic [LOG_RAS_DEPTH-1:0]    ras_index;
    logic [LOG_RAS_DEPTH:0]      ras_count;
    logic                        update_valid;
    logic [LOG_RAS_DEPTH-1:0]    update_ras_index;
    logic [LOG_RAS_DEPTH:0]      update_ras_count;

    // Predict-stage / backend side
    modport master (
        output link_valid, link_target, ret_valid,
        output update_valid, update_ras_index, update_ras_count,
        input  ret_target, ret_empty, ras_index, ras_count
    );

    // Stack side
    modport slave (
        input  link_valid, link_target, ret_valid,
        input  update_valid, update_ras_index, update_ras_count,
        output ret_target, ret_empty, ras_index, ras_count
    );
endinterface

// File: rtl/ras.sv
// Return address stack: pushes call link targets, supplies return targets,
// and restores pointer/occupancy from a mispredict checkpoint.
module ras #(
    parameter int unsigned RAS_DEPTH        = 8,
    parameter int unsigned LOG_RAS_DEPTH    = $clog2(RAS_DEPTH),
    parameter int unsigned RAS_TARGET_WIDTH = 8
) (
    input  logic CLK,
    input  logic nRST,
    ras_if.slave bus
);
    localparam int unsigned PTR_W = LOG_RAS_DEPTH;
    localparam int unsigned CNT_W = LOG_RAS_DEPTH + 1;
    localparam int unsigned TGT_W = RAS_TARGET_WIDTH;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

    logic [TGT_W-1:0] stack_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             push_c;
    logic             pop_c;
    logic             swap_c;
    logic             wr_en_c;
    logic [PTR_W-1:0] wr_idx_c;
    logic [CNT_W-1:0] restore_count_c;

    // Request decode; a restore masks any push/pop in the same cycle
    always_comb begin
        push_c = bus.link_valid & ~bus.ret_valid & ~bus.update_valid;
        pop_c  = bus.ret_valid & ~bus.link_valid & ~bus.update_valid;
        swap_c = bus.link_valid & bus.ret_valid & ~bus.update_valid;
    end

    // Out-of-range checkpoint occupancy is clamped to a full stack
    always_comb begin
        restore_count_c = bus.update_ras_count;
        if (bus.update_ras_count > FULL_COUNT) begin
            restore_count_c = FULL_COUNT;
        end
    end

    // Next pointer/occupancy and stack write port
    always_comb begin
        ptr_d    = ptr_q;
        count_d  = count_q;
        wr_en_c  = 1'b0;
        wr_idx_c = ptr_q;

        if (bus.update_valid) begin
            ptr_d   = bus.update_ras_index;
            count_d = restore_count_c;
        end else if (push_c) begin
            // Pointer wraps naturally; a push when full overwrites the oldest entry
            wr_en_c  = 1'b1;
            wr_idx_c = ptr_q + PTR_W'(1);
            ptr_d    = ptr_q + PTR_W'(1);
            if (count_q != FULL_COUNT) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_c) begin
            if (count_q != '0) begin
                ptr_d   = ptr_q - PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
        end else if (swap_c) begin
            // Co-routine call/return replaces the top in place
            wr_en_c  = 1'b1;
            wr_idx_c = ptr_q;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Stack storage
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            stack_q[wr_idx_c] <= bus.link_target;
        end
    end

    // Outputs reflect registered state before this cycle's update
    assign bus.ret_target = stack_q[ptr_q];
    assign bus.ret_empty  = (count_q == '0);
    assign bus.ras_index  = ptr_q;
    assign bus.ras_count  = count_q;

endmodule

// File: tb/tb_ras.sv
// Testbench for ras: directed scenarios plus randomized traffic against a
// behavioural stack model.
module tb_ras;
    localparam int DEPTH = 8;
    localparam int LOGD  = 3;
    localparam int TW    = 8;

    logic CLK;
    logic nRST;

    ras_if #(.RAS_DEPTH(DEPTH), .LOG_RAS_DEPTH(LOGD), .RAS_TARGET_WIDTH(TW)) bus ();

    ras #(.RAS_DEPTH(DEPTH), .LOG_RAS_DEPTH(LOGD), .RAS_TARGET_WIDTH(TW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain array, top index and occupancy
    int m_stk [DEPTH];
    int m_ptr;
    int m_count;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_stk[i] = 0;
        m_ptr   = 0;
        m_count = 0;
    endtask

    task automatic model_apply(input bit lv, input int lt, input bit rv,
                               input bit uv, input int ui, input int uc);
        if (uv) begin
            m_ptr   = ui % DEPTH;
            m_count = (uc > DEPTH) ? DEPTH : uc;
        end else if (lv && !rv) begin
            m_ptr        = (m_ptr + 1) % DEPTH;
            m_stk[m_ptr] = lt;
            m_count      = (m_count + 1 > DEPTH) ? DEPTH : m_count + 1;
        end else if (rv && !lv) begin
            if (m_count > 0) begin
                m_ptr   = (m_ptr + DEPTH - 1) % DEPTH;
                m_count = m_count - 1;
            end
        end else if (lv && rv) begin
            m_stk[m_ptr] = lt;
        end
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, ".ret_target"}, int'(bus.ret_target), m_stk[m_ptr]);
        check({tag, ".ret_empty"},  int'(bus.ret_empty),  (m_count == 0) ? 1 : 0);
        check({tag, ".ras_index"},  int'(bus.ras_index),  m_ptr);
        check({tag, ".ras_count"},  int'(bus.ras_count),  m_count);
    endtask

    task automatic idle_inputs();
        bus.link_valid       = 1'b0;
        bus.link_target      = '0;
        bus.ret_valid        = 1'b0;
        bus.update_valid     = 1'b0;
        bus.update_ras_index = '0;
        bus.update_ras_count = '0;
    endtask

    // One clock: drive at negedge, check pre-state, clock, update model
    task automatic step(input bit lv, input int lt, input bit rv,
                        input bit uv, input int ui, input int uc);
        @(negedge CLK);
        bus.link_valid       = lv;
        bus.link_target      = TW'(lt);
        bus.ret_valid        = rv;
        bus.update_valid     = uv;
        bus.update_ras_index = LOGD'(ui);
        bus.update_ras_count = (LOGD + 1)'(uc);
        #1;
        compare_outputs("pre");
        @(posedge CLK);
        model_apply(lv, lt, rv, uv, ui, uc);
        #1;
        idle_inputs();
    endtask

    task automatic push(input int v);
        step(1'b1, v, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic pop();
        step(1'b0, 0, 1'b1, 1'b0, 0, 0);
    endtask

    // Asynchronous reset between edges; requests presented during reset are dropped
    task automatic do_reset();
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        check("rst.ras_count",  int'(bus.ras_count),  0);
        check("rst.ret_target", int'(bus.ret_target), 0);
        check("rst.ret_empty",  int'(bus.ret_empty),  1);
        check("rst.ras_index",  int'(bus.ras_index),  0);
        model_reset();
        bus.link_valid  = 1'b1;
        bus.link_target = TW'($urandom);
        @(posedge CLK);
        #1;
        check("rst_hold.ras_count", int'(bus.ras_count), 0);
        idle_inputs();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        int cp_idx;
        int cp_cnt;
        nRST = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        nRST = 1'b1;

        // Basic push/pop
        do_reset();
        push(8'h11); push(8'h22); push(8'h33);
        check("basic.top0", int'(bus.ret_target), 8'h33);
        check("basic.cnt0", int'(bus.ras_count), 3);
        pop();
        check("basic.top1", int'(bus.ret_target), 8'h22);
        check("basic.cnt1", int'(bus.ras_count), 2);
        pop();
        check("basic.top2", int'(bus.ret_target), 8'h11);
        check("basic.cnt2", int'(bus.ras_count), 1);
        pop();
        check("basic.cnt3",  int'(bus.ras_count), 0);
        check("basic.empty", int'(bus.ret_empty), 1);

        // Overflow: nine pushes into eight entries
        do_reset();
        for (int v = 1; v <= 9; v++) push(v);
        check("ovf.count", int'(bus.ras_count), 8);
        check("ovf.index", int'(bus.ras_index), 1);
        check("ovf.top",   int'(bus.ret_target), 9);
        for (int k = 0; k < 8; k++) begin
            check("ovf.pop_top", int'(bus.ret_target), 9 - k);
            pop();
        end
        check("ovf.empty", int'(bus.ret_empty), 1);

        // Simultaneous push and pop
        do_reset();
        push(8'h30); push(8'h40);
        check("swap.old_top", int'(bus.ret_target), 8'h40);
        step(1'b1, 8'h55, 1'b1, 1'b0, 0, 0);
        check("swap.new_top", int'(bus.ret_target), 8'h55);
        check("swap.count",   int'(bus.ras_count), 2);
        check("swap.index",   int'(bus.ras_index), 2);

        // Push and pop together on an empty stack keeps count at zero
        do_reset();
        step(1'b1, 8'h66, 1'b1, 1'b0, 0, 0);
        check("swap_empty.count", int'(bus.ras_count), 0);
        check("swap_empty.top",   int'(bus.ret_target), 8'h66);

        // Restore from checkpoint, with a push in the same cycle ignored
        do_reset();
        push(8'hA0);
        cp_idx = int'(bus.ras_index);
        cp_cnt = int'(bus.ras_count);
        check("rest.cp_idx", cp_idx, 1);
        check("rest.cp_cnt", cp_cnt, 1);
        push(8'hB0); push(8'hC0); pop();
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1, 1);
        check("rest.index", int'(bus.ras_index), 1);
        check("rest.count", int'(bus.ras_count), 1);
        check("rest.top",   int'(bus.ret_target), 8'hA0);
        step(1'b0, 0, 1'b0, 1'b1, 2, 2);
        check("rest.no_ee2", int'(bus.ret_target), 8'hB0);
        step(1'b0, 0, 1'b0, 1'b1, 3, 3);
        check("rest.no_ee3", int'(bus.ret_target), 8'hC0);
        step(1'b0, 0, 1'b0, 1'b1, 5, 15);
        check("rest.clamp", int'(bus.ras_count), 8);
        check("rest.idx5",  int'(bus.ras_index), 5);

        // Pop on empty
        do_reset();
        for (int k = 0; k < 3; k++) begin
            pop();
            check("empty_pop.index", int'(bus.ras_index), 0);
            check("empty_pop.count", int'(bus.ras_count), 0);
            check("empty_pop.empty", int'(bus.ret_empty), 1);
        end

        // Reset mid-operation
        push(8'h77); push(8'h88);
        check("midrst.pre_count", int'(bus.ras_count), 2);
        do_reset();
        check("midrst.post_count", int'(bus.ras_count), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            bit lv;
            bit rv;
            bit uv;
            int uc;
            r  = int'($urandom_range(0, 199));
            if (r == 0) begin
                do_reset();
            end else begin
                uv = ($urandom_range(0, 99) < 8);
                lv = ($urandom_range(0, 99) < 50);
                rv = ($urandom_range(0, 99) < 40);
                uc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                                 : int'($urandom_range(0, 8));
                step(lv, int'($urandom_range(0, 255)), rv, uv,
                     int'($urandom_range(0, 7)), uc);
            end
        end
        compare_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ras.md
# ras

Return address stack for the front-end branch predictor. It pushes link targets for predicted calls and supplies predicted targets for returns in the same cycle the return is seen. On a mispredict, the backend restores the stack pointer and occupancy from a checkpoint. It sits beside the BTB in the predict stage and feeds the target-select mux. Targets are the low `RAS_TARGET_WIDTH` bits only; upper bits come from the upper-PC table.

## Interface
Parameters:
- `RAS_DEPTH`, default 8: number of stack entries; must be a power of 2.
- `LOG_RAS_DEPTH`, default `$clog2(RAS_DEPTH)`: pointer width.
- `RAS_TARGET_WIDTH`, default 8: stored target width.

Ports:
- `CLK` in 1: clock; all state is on the rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `link_valid` in 1: push request, i.e. a predicted call.
- `link_target` in `RAS_TARGET_WIDTH`: return address to push.
- `ret_valid` in 1: pop request, i.e. a predicted return.
- `ret_target` out `RAS_TARGET_WIDTH`: current top entry (combinational).
- `ret_empty` out 1: `count == 0`.
- `ras_index` out `LOG_RAS_DEPTH`: current top pointer; captured as the checkpoint with each branch.
- `ras_count` out `LOG_RAS_DEPTH+1`: current occupancy; captured as the checkpoint.
- `update_valid` in 1: restore request from a mispredict.
- `update_ras_index` in `LOG_RAS_DEPTH`: checkpointed pointer to restore.
- `update_ras_count` in `LOG_RAS_DEPTH+1`: checkpointed occupancy to restore.

## Operation
State:
- `stack[RAS_DEPTH]`: the target entries.
- `ptr`: index of the top valid entry.
- `count`: occupancy, range 0..`RAS_DEPTH`.

Output mapping:
- `ret_target = stack[ptr]`.
- `ras_index = ptr`.
- `ras_count = count`.

Cycle update, in priority order:
- **`update_valid`**: `ptr <= update_ras_index`; `count <= update_ras_count`. `link_valid` and `ret_valid` are ignored in that cycle. Stack contents are unchanged.
- **Push only** (`link_valid & ~ret_valid`):
  - `stack[ptr+1] <= link_target`.
  - `ptr <= ptr+1`, wrapping modulo `RAS_DEPTH`.
  - `count <= min(count+1, RAS_DEPTH)`.
- **Pop only** (`ret_valid & ~link_valid`):
  - If `count > 0`: `ptr <= ptr-1` (wrapping) and `count <= count-1`.
  - If `count == 0`: no state change. `ret_target` still shows the stale `stack[ptr]`; the consumer uses `ret_empty` to fall back to the BTB target.
- **Push and pop together** (co-routine call/return):
  - `ret_target` returns the old `stack[ptr]`.
  - `stack[ptr] <= link_target`.
  - `ptr` and `count` are unchanged, including when `count == 0`, in which case `count` stays 0.
- **Neither**: hold.

Overflow:
- A push at `count == RAS_DEPTH` wraps and overwrites the oldest entry.
- `count` stays at `RAS_DEPTH`.

Restore:
- Restores `ptr` and `count` only. Entries overwritten since the checkpoint are not repaired; a target corrupted this way is an accepted mispredict source.
- `update_ras_count` greater than `RAS_DEPTH` is illegal input. Clamp it to `RAS_DEPTH`.

## Timing
- `ret_target`, `ret_empty`, `ras_index` and `ras_count` are combinational from registered state. They reflect state before the current cycle's push, pop or restore.
- The new top is visible the cycle after a push, pop or restore.
- A push followed by a pop in the next cycle returns the just-pushed target; no bypass is needed.
- Reset: asynchronous assertion and synchronous-to-`CLK` deassertion behaviour come from `nRST` directly. On reset:
  - all `stack` entries = 0, `ptr` = 0, `count` = 0.
  - outputs: `ret_target` = 0, `ret_empty` = 1, `ras_index` = 0, `ras_count` = 0.
- Reset mid-operation: state is cleared immediately. A push, pop or restore presented during reset is discarded.

## Test plan
- **Basic push/pop:** after reset, push 0x11, 0x22, 0x33 on consecutive cycles, then pop three times. Required: `ret_target` = 0x33, 0x22, 0x11 on the pop cycles; `ras_count` = 3, 2, 1, 0; then `ret_empty` = 1.
- **Overflow:** push 0x01..0x09 (9 pushes). Required: `ras_count` = 8, `ras_index` = 1, `ret_target` = 0x09. Then 8 pops give 0x09..0x02, and `ret_empty` = 1 after the eighth.
- **Simultaneous push+pop:** with top = 0x40 and count 2, assert `link_valid` (0x55) and `ret_valid` together. Required: `ret_target` = 0x40 that cycle; the next cycle shows `ret_target` = 0x55, `ras_count` = 2, and `ras_index` unchanged.
- **Restore:**
  - Push 0xA0 and checkpoint (`ras_index` = 1, `ras_count` = 1).
  - Push 0xB0 and 0xC0, then pop once.
  - Assert `update_valid` with (1, 1) together with `link_valid` (0xEE).
  - Required: next cycle `ras_index` = 1, `ras_count` = 1, `ret_target` = 0xA0, and 0xEE is never written.
- **Pop on empty:** after reset, assert `ret_valid` for 3 cycles. Required: `ras_index` = 0, `ras_count` = 0, and `ret_empty` = 1 throughout.
- **Reset mid-operation:** push 0x77, 0x88, then assert `nRST` = 0 between clock edges. Required: `ras_count` = 0, `ret_target` = 0 and `ret_empty` = 1 immediately, without waiting for a clock edge.
